// File: rtl/gcm_aes_decrypt.sv
// GCM-AES receive side: CTR decrypt with an external AES keystream port and an internal GHASH tag check.
// Optional GCM_DEC_FAST_GHASH_EN: GHASH multiplier consumes 4 bits of Y per cycle instead of 1.
module gcm_aes_decrypt #(
   parameter int BLK_W   = 8,
   parameter int TAG_LEN = 128
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [95:0]      i_iv,
   input  logic [BLK_W-1:0] i_aad_blocks,
   input  logic [BLK_W-1:0] i_ct_blocks,
   input  logic [127:0]     i_tag,
   input  logic [127:0]     i_data,
   input  logic             i_data_valid,
   output logic             o_data_ready,
   output logic [127:0]     o_ctr_block,
   output logic             o_ks_req,
   input  logic [127:0]     i_ks,
   input  logic             i_ks_valid,
   output logic [127:0]     o_pt,
   output logic             o_pt_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_tag_ok
);

`ifdef GCM_DEC_FAST_GHASH_EN
   localparam int BPC = 4;
`else
   localparam int BPC = 1;
`endif
   localparam logic [6:0]   MUL_LAST = 7'(128 / BPC - 1);
   localparam logic [127:0] R_POLY   = {8'hE1, 120'h0};

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_H_REQ   = 4'd1;
   localparam logic [3:0] S_H_WAIT  = 4'd2;
   localparam logic [3:0] S_J0_REQ  = 4'd3;
   localparam logic [3:0] S_J0_WAIT = 4'd4;
   localparam logic [3:0] S_AAD_IN  = 4'd5;
   localparam logic [3:0] S_AAD_MUL = 4'd6;
   localparam logic [3:0] S_KS_REQ  = 4'd7;
   localparam logic [3:0] S_KS_WAIT = 4'd8;
   localparam logic [3:0] S_CT_IN   = 4'd9;
   localparam logic [3:0] S_CT_MUL  = 4'd10;
   localparam logic [3:0] S_LEN_MUL = 4'd11;
   localparam logic [3:0] S_FINAL   = 4'd12;

   logic [3:0]       state;
   logic [95:0]      iv;
   logic [BLK_W-1:0] aad_n, ct_n, blk_cnt;
   logic [127:0]     tag, h, ej0, y, ks;
   logic [127:0]     z, v, x;
   logic [31:0]      ctr;
   logic [6:0]       mcnt;

   logic [127:0] z_nxt, v_nxt, x_nxt, len_blk, t;
   logic         in_mul, mul_done, tag_match;

   // Vector index 127 is GCM bit 0, so "toward higher GCM indices" is a plain >> here.
   always_comb begin
      z_nxt = z;
      v_nxt = v;
      x_nxt = x;
      for (int i = 0; i < BPC; i++) begin
         if (x_nxt[127]) z_nxt = z_nxt ^ v_nxt;
         v_nxt = v_nxt[0] ? ((v_nxt >> 1) ^ R_POLY) : (v_nxt >> 1);
         x_nxt = x_nxt << 1;
      end
   end

   assign len_blk   = {{(57-BLK_W){1'b0}}, aad_n, 7'b0, {(57-BLK_W){1'b0}}, ct_n, 7'b0};
   assign in_mul    = (state == S_AAD_MUL) || (state == S_CT_MUL) || (state == S_LEN_MUL);
   assign mul_done  = (mcnt == MUL_LAST);
   assign t         = y ^ ej0;
   assign tag_match = (t[127 -: TAG_LEN] == tag[127 -: TAG_LEN]);

   assign o_busy       = (state != S_IDLE);
   assign o_data_ready = (state == S_AAD_IN) || (state == S_CT_IN);
   assign o_ks_req     = (state == S_H_REQ) || (state == S_J0_REQ) || (state == S_KS_REQ);

   always_comb begin
      case (state)
         S_J0_REQ, S_J0_WAIT: o_ctr_block = {iv, 32'd1};
         S_KS_REQ, S_KS_WAIT: o_ctr_block = {iv, ctr};
         default:             o_ctr_block = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         iv         <= '0;
         aad_n      <= '0;
         ct_n       <= '0;
         blk_cnt    <= '0;
         tag        <= '0;
         h          <= '0;
         ej0        <= '0;
         y          <= '0;
         ks         <= '0;
         z          <= '0;
         v          <= '0;
         x          <= '0;
         ctr        <= '0;
         mcnt       <= '0;
         o_pt       <= '0;
         o_pt_valid <= 1'b0;
         o_done     <= 1'b0;
         o_tag_ok   <= 1'b0;
      end else begin
         o_pt_valid <= 1'b0;
         o_done     <= 1'b0;
         if (in_mul) begin
            z    <= z_nxt;
            v    <= v_nxt;
            x    <= x_nxt;
            mcnt <= mcnt + 7'd1;
         end
         // Multiply loads below override the step above: z=0, v=H, x=operand.
         case (state)
            S_IDLE: if (i_start) begin
               iv       <= i_iv;
               aad_n    <= i_aad_blocks;
               ct_n     <= i_ct_blocks;
               tag      <= i_tag;
               y        <= '0;
               ctr      <= 32'd2;
               blk_cnt  <= '0;
               o_tag_ok <= 1'b0;
               state    <= S_H_REQ;
            end
            S_H_REQ:  state <= S_H_WAIT;
            S_H_WAIT: if (i_ks_valid) begin
               h     <= i_ks;
               state <= S_J0_REQ;
            end
            S_J0_REQ:  state <= S_J0_WAIT;
            S_J0_WAIT: if (i_ks_valid) begin
               ej0 <= i_ks;
               if (aad_n != '0) state <= S_AAD_IN;
               else if (ct_n != '0) state <= S_KS_REQ;
               else begin
                  z <= '0; v <= h; x <= y ^ len_blk; mcnt <= '0;
                  state <= S_LEN_MUL;
               end
            end
            S_AAD_IN: if (i_data_valid) begin
               z <= '0; v <= h; x <= y ^ i_data; mcnt <= '0;
               blk_cnt <= blk_cnt + BLK_W'(1);
               state   <= S_AAD_MUL;
            end
            S_AAD_MUL: if (mul_done) begin
               y <= z_nxt;
               if (blk_cnt != aad_n) state <= S_AAD_IN;
               else if (ct_n != '0) begin
                  blk_cnt <= '0;
                  state   <= S_KS_REQ;
               end else begin
                  z <= '0; v <= h; x <= z_nxt ^ len_blk; mcnt <= '0;
                  state <= S_LEN_MUL;
               end
            end
            S_KS_REQ:  state <= S_KS_WAIT;
            S_KS_WAIT: if (i_ks_valid) begin
               ks    <= i_ks;
               state <= S_CT_IN;
            end
            S_CT_IN: if (i_data_valid) begin
               o_pt       <= i_data ^ ks;
               o_pt_valid <= 1'b1;
               z <= '0; v <= h; x <= y ^ i_data; mcnt <= '0;
               blk_cnt <= blk_cnt + BLK_W'(1);
               ctr     <= ctr + 32'd1;
               state   <= S_CT_MUL;
            end
            S_CT_MUL: if (mul_done) begin
               y <= z_nxt;
               if (blk_cnt != ct_n) state <= S_KS_REQ;
               else begin
                  z <= '0; v <= h; x <= z_nxt ^ len_blk; mcnt <= '0;
                  state <= S_LEN_MUL;
               end
            end
            S_LEN_MUL: if (mul_done) begin
               y     <= z_nxt;
               state <= S_FINAL;
            end
            S_FINAL: begin
               o_tag_ok <= tag_match;
               o_done   <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcm_aes_decrypt.sv
// Scoreboard bench for gcm_aes_decrypt; keystream answers come from a table of known AES outputs
// for the two GCM reference keys, and the AAD case uses a behavioural GHASH model.
module tb_gcm_aes_decrypt;

   localparam logic [127:0] H0     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] EJ0_0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [127:0] KS0_2  = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [127:0] H1     = 128'hb83b533708bf535d0aa6e52980d53b78;
   localparam logic [127:0] EJ0_1  = 128'h3247184b3c4f69a44dbcd22887bbb418;
   localparam logic [95:0]  IV1    = 96'hcafebabefacedbaddecaf888;
   localparam logic [127:0] TAG3   = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
   localparam logic [127:0] TC3_C [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                                          128'he3aa212f2c02a4e035c17e2329aca12e,
                                          128'h21d514b25466931c7d8f6a5aac84aa05,
                                          128'h1ba30b396a0aac973d58e091473f5985};
   localparam logic [127:0] TC3_P [4] = '{128'hd9313225f88406e5a55909c5aff5269a,
                                          128'h86a7a9531534f7da2e4c303d8a318a72,
                                          128'h1c3c0c95956809532fcf0e2449a6b525,
                                          128'hb16aedf5aa0de657ba637b391aafd255};

   logic         clk = 0;
   logic         i_rst = 1;
   logic         i_start = 0;
   logic [95:0]  i_iv = '0;
   logic [7:0]   i_aad_blocks = '0, i_ct_blocks = '0;
   logic [127:0] i_tag = '0, i_data = '0, i_ks = '0;
   logic         i_data_valid = 0, i_ks_valid = 0;
   logic         o_data_ready, o_ks_req, o_pt_valid, o_busy, o_done, o_tag_ok;
   logic [127:0] o_ctr_block, o_pt;

   gcm_aes_decrypt dut (
      .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_iv(i_iv),
      .i_aad_blocks(i_aad_blocks), .i_ct_blocks(i_ct_blocks), .i_tag(i_tag),
      .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
      .o_ctr_block(o_ctr_block), .o_ks_req(o_ks_req), .i_ks(i_ks), .i_ks_valid(i_ks_valid),
      .o_pt(o_pt), .o_pt_valid(o_pt_valid), .o_busy(o_busy), .o_done(o_done), .o_tag_ok(o_tag_ok)
   );

   always #5 clk = ~clk;

   int nchk = 0, nbad = 0, done_cnt = 0, ks_stall = 0;
   bit key_sel = 0;
   logic [127:0] exp_pt[$];
   bit           exp_ok[$];
   logic [95:0]  m_iv;
   logic [127:0] m_aad[$], m_ct[$];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nchk++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] ks_of(input bit ksel, input logic [127:0] blk, output bit found);
      found = 1;
      if (!ksel) begin
         if (blk == 128'd0) return H0;
         if (blk == 128'd1) return EJ0_0;
         if (blk == 128'd2) return KS0_2;
      end else begin
         if (blk == 128'd0) return H1;
         if (blk == {IV1, 32'd1}) return EJ0_1;
         for (int n = 0; n < 4; n++)
            if (blk == {IV1, 32'(n + 2)}) return TC3_C[n] ^ TC3_P[n];
      end
      found = 0;
      return '0;
   endfunction

   function automatic logic [127:0] gmul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] zz = '0, vv = b;
      for (int i = 0; i < 128; i++) begin
         if (a[127 - i]) zz ^= vv;
         vv = vv[0] ? ((vv >> 1) ^ {8'he1, 120'h0}) : (vv >> 1);
      end
      return zz;
   endfunction

   // Keystream responder: answers each request after ks_stall cycles in the WAIT state.
   initial begin
      logic [127:0] blk;
      bit f;
      forever begin
         if (o_ks_req === 1'b1) begin
            blk = o_ctr_block;
            @(posedge clk); #1;
            for (int s = 0; s < ks_stall; s++) begin
               chk("ctr_hold", o_ctr_block, blk);
               @(posedge clk); #1;
            end
            chk("ctr_hold", o_ctr_block, blk);
            i_ks = ks_of(key_sel, blk, f);
            chk("ctr_known", 128'(f), 128'd1);
            i_ks_valid = 1;
            @(posedge clk); #1;
            i_ks_valid = 0;
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   always @(negedge clk) begin
      if (!i_rst) begin
         if (o_pt_valid) begin
            if (exp_pt.size() == 0) chk("pt_unexpected", 128'(exp_pt.size()), 128'd1);
            else chk("pt", o_pt, exp_pt.pop_front());
         end
         if (o_done) begin
            done_cnt++;
            if (exp_ok.size() == 0) chk("done_unexpected", 128'(exp_ok.size()), 128'd1);
            else chk("tag_ok", 128'(o_tag_ok), 128'(exp_ok.pop_front()));
         end
      end
   end

   task automatic run_msg(input logic [127:0] tag, input bit ok, input int abort_at,
                          input bit drop, input bit dup_start);
      logic [127:0] d_all[$];
      int idx = 0, cyc = 0, lim, done0;
      bit xfer = 0, f;
      foreach (m_aad[k]) d_all.push_back(m_aad[k]);
      foreach (m_ct[k]) d_all.push_back(m_ct[k]);
      lim = (abort_at > 0) ? abort_at : d_all.size();
      foreach (m_ct[n])
         if (abort_at == 0 || m_aad.size() + n < abort_at)
            exp_pt.push_back(m_ct[n] ^ ks_of(key_sel, {m_iv, 32'(n + 2)}, f));
      if (abort_at == 0) exp_ok.push_back(ok);
      done0 = done_cnt;
      @(negedge clk);
      i_iv = m_iv; i_aad_blocks = 8'(m_aad.size()); i_ct_blocks = 8'(m_ct.size());
      i_tag = tag; i_start = 1;
      @(negedge clk);
      i_start = 0;
      while (idx < lim && cyc < 5000) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         if (xfer) idx++;
         xfer = 0;
         i_start = (dup_start && cyc == 3);
         if (i_start) i_iv = 96'($urandom);
         if (idx < lim) begin
            i_data = d_all[idx];
            i_data_valid = drop ? ($urandom_range(0, 2) != 0) : 1'b1;
            xfer = i_data_valid && o_data_ready;
         end
      end
      i_data_valid = 0; i_start = 0;
      chk("fed_all", 128'(idx), 128'(lim));
      if (abort_at > 0) begin
         repeat (8) @(negedge clk);
         i_rst = 1;
         repeat (2) @(negedge clk);
         i_rst = 0;
         @(negedge clk);
         chk("abort_idle", 128'(o_busy), 128'd0);
         repeat (300) @(negedge clk);
         chk("abort_no_done", 128'(done_cnt), 128'(done0));
      end else begin
         cyc = 0;
         while (done_cnt == done0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
         end
         chk("done_seen", 128'(done_cnt), 128'(done0 + 1));
         @(negedge clk);
         chk("busy_after", 128'(o_busy), 128'd0);
      end
      chk("pt_all_seen", 128'(exp_pt.size()), 128'd0);
      exp_pt.delete(); exp_ok.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d", nchk);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] yy, tag_a;
      repeat (3) @(negedge clk);
      chk("rst_busy", 128'(o_busy), 128'd0);
      chk("rst_done", 128'(o_done), 128'd0);
      chk("rst_tag_ok", 128'(o_tag_ok), 128'd0);
      chk("rst_pt_valid", 128'(o_pt_valid), 128'd0);
      chk("rst_ready", 128'(o_data_ready), 128'd0);
      chk("rst_ks_req", 128'(o_ks_req), 128'd0);
      chk("rst_pt", o_pt, 128'd0);
      i_rst = 0;
      @(negedge clk);

      // Zero-key vectors: empty message, then one zero-plaintext block.
      key_sel = 0; m_iv = '0;
      run_msg(EJ0_0, 1, 0, 0, 0);
      m_ct.push_back(KS0_2);
      run_msg(128'hab6e47d42cec13bdf53a67b21257bddf, 1, 0, 0, 0);

      // Four-block vector: good tag, flipped last tag bit, then stalls and valid drops.
      key_sel = 1; m_iv = IV1; m_ct.delete();
      for (int n = 0; n < 4; n++) m_ct.push_back(TC3_C[n]);
      run_msg(TAG3, 1, 0, 0, 1);
      run_msg(TAG3 ^ 128'd1, 0, 0, 0, 0);
      ks_stall = 50;
      run_msg(TAG3, 1, 0, 1, 0);
      ks_stall = 0;

      // Abort inside the first CT multiply, then the full message again.
      run_msg(TAG3, 1, 1, 0, 0);
      run_msg(TAG3, 1, 0, 0, 0);

      // Two AAD blocks plus two CT blocks, tag from the GHASH model.
      m_ct.delete();
      for (int k = 0; k < 2; k++) m_aad.push_back({$urandom, $urandom, $urandom, $urandom});
      for (int n = 0; n < 2; n++) m_ct.push_back(TC3_C[n]);
      yy = '0;
      foreach (m_aad[k]) yy = gmul(yy ^ m_aad[k], H1);
      foreach (m_ct[k]) yy = gmul(yy ^ m_ct[k], H1);
      yy = gmul(yy ^ {64'd256, 64'd256}, H1);
      tag_a = yy ^ EJ0_1;
      run_msg(tag_a, 1, 0, 1, 0);
      run_msg(tag_a ^ {8'h80, 120'h0}, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", nchk, nbad);
      $finish;
   end

endmodule
